// File: rtl/decoder_nx_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_nx_seq
// Purpose  : Registered N-to-2**N one-hot decoder with hold, scan and
//            single-pass scan modes; all outputs registered.
// Revision : 1.0
// ============================================================================
module decoder_nx_seq #(
    parameter int N          = 2,
    parameter int SCAN_DIV   = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            En,
    input  logic [N-1:0]    A,
    input  logic [1:0]      mode,
    output logic [2**N-1:0] Y,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap,
    output logic            done
);

    localparam int                 c_y_w     = 2**N;
    localparam int                 c_cnt_w   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_tc      = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [N-1:0]       c_idx_max = '1;
    localparam logic [N-1:0]       c_idx_one = N'(1);
    localparam logic [c_y_w-1:0]   c_y_one   = c_y_w'(1);
    localparam logic [c_y_w-1:0]   c_pol     = (ACTIVE_LOW != 0) ? '1 : '0;

    localparam logic [1:0] c_mode_decode = 2'b00;
    localparam logic [1:0] c_mode_hold   = 2'b01;
    localparam logic [1:0] c_mode_scan   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_ONCE   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;

    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [N-1:0]       w_idx_nxt;
    logic               w_valid_nxt;
    logic               w_wrap_nxt;
    logic               w_done_nxt;
    logic               w_tc;
    logic [c_y_w-1:0]   w_y_nxt;

    // The counter defaults to zero, so every state change restarts the step period.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_idx_nxt   = idx;
        w_valid_nxt = valid;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_tc        = (r_cnt == c_tc);
        if (!En) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
        end else begin
            case (mode)
                c_mode_decode: begin
                    w_state_nxt = ST_DECODE;
                    w_idx_nxt   = A;
                    w_valid_nxt = 1'b1;
                end
                c_mode_hold: begin
                    w_state_nxt = ST_HOLD;
                end
                c_mode_scan: begin
                    w_state_nxt = ST_SCAN;
                    w_valid_nxt = 1'b1;
                    if (r_state == ST_SCAN) begin
                        if (w_tc) begin
                            w_idx_nxt  = idx + c_idx_one;
                            w_wrap_nxt = (idx == c_idx_max);
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                end
                default: begin
                    // Single pass: DONE persists until mode leaves 11.
                    w_valid_nxt = 1'b1;
                    if (r_state == ST_DONE) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else if (r_state == ST_ONCE) begin
                        w_state_nxt = ST_ONCE;
                        if (w_tc) begin
                            if (idx == c_idx_max) begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_idx_nxt = idx + c_idx_one;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end else begin
                        w_state_nxt = ST_ONCE;
                    end
                end
            endcase
        end
        w_y_nxt = (w_valid_nxt ? (c_y_one << w_idx_nxt) : '0) ^ c_pol;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            Y       <= c_pol;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            idx     <= w_idx_nxt;
            valid   <= w_valid_nxt;
            wrap    <= w_wrap_nxt;
            done    <= w_done_nxt;
            Y       <= w_y_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_nx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_nx_seq
// Purpose  : Directed self-checking bench for decoder_nx_seq.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_decoder_nx_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [2:0] a;

    always #5 clk = ~clk;

    logic [3:0] y0;  logic [1:0] idx0; logic valid0, wrap0, done0;
    logic [3:0] y1;  logic [1:0] idx1; logic valid1, wrap1, done1;
    logic [7:0] y2;  logic [2:0] idx2; logic valid2, wrap2, done2;
    logic [3:0] y3;  logic [1:0] idx3; logic valid3, wrap3, done3;

    decoder_nx_seq #(.N(2), .SCAN_DIV(3), .ACTIVE_LOW(0)) u_dut_scan (
        .clk(clk), .rst(rst), .En(en), .A(a[1:0]), .mode(mode),
        .Y(y0), .idx(idx0), .valid(valid0), .wrap(wrap0), .done(done0)
    );

    decoder_nx_seq #(.N(2), .SCAN_DIV(3), .ACTIVE_LOW(1)) u_dut_inv (
        .clk(clk), .rst(rst), .En(en), .A(a[1:0]), .mode(mode),
        .Y(y1), .idx(idx1), .valid(valid1), .wrap(wrap1), .done(done1)
    );

    decoder_nx_seq #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(0)) u_dut_once (
        .clk(clk), .rst(rst), .En(en), .A(a), .mode(mode),
        .Y(y2), .idx(idx2), .valid(valid2), .wrap(wrap2), .done(done2)
    );

    decoder_nx_seq #(.N(2), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_dut_hold (
        .clk(clk), .rst(rst), .En(en), .A(a[1:0]), .mode(mode),
        .Y(y3), .idx(idx3), .valid(valid3), .wrap(wrap3), .done(done3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [1:0] e_idx;
        logic [3:0] e_y;

        rst = 1'b1; en = 1'b0; mode = 2'b00; a = 3'd0;
        step(1);
        check("rst_y",      64'(y0), 64'h0);
        check("rst_y_inv",  64'(y1), 64'hF);
        check("rst_idx",    64'(idx0), 64'h0);
        check("rst_valid",  64'(valid0), 64'h0);
        check("rst_wrap",   64'(wrap0), 64'h0);
        check("rst_done",   64'(done0), 64'h0);
        check("rst_done_inv", 64'(done1), 64'h0);
        rst = 1'b0;

        // DECODE, both polarities
        en = 1'b1; mode = 2'b00; a = 3'd3;
        step(1);
        check("dec3_y",     64'(y0), 64'h8);
        check("dec3_y_inv", 64'(y1), 64'h7);
        check("dec3_idx",   64'(idx0), 64'h3);
        check("dec3_valid", 64'(valid0), 64'h1);
        a = 3'd0;
        step(1);
        check("dec0_y",     64'(y0), 64'h1);
        check("dec0_y_inv", 64'(y1), 64'hE);
        a = 3'd2;
        step(1);
        check("dec2_y",     64'(y0), 64'h4);
        check("dec2_y_inv", 64'(y1), 64'hB);
        check("dec2_idx_inv", 64'(idx1), 64'h2);
        check("dec2_valid_inv", 64'(valid1), 64'h1);

        // SCAN with SCAN_DIV=3 from idx 0
        a = 3'd0;
        step(1);
        mode = 2'b10;
        step(1);
        for (int k = 0; k < 14; k++) begin
            e_idx = 2'((k / 3) % 4);
            e_y   = 4'b0001 << e_idx;
            check($sformatf("scan_idx_k%0d", k),  64'(idx0), 64'(e_idx));
            check($sformatf("scan_wrap_k%0d", k), 64'(wrap0), (k == 12) ? 64'h1 : 64'h0);
            check($sformatf("scan_y_k%0d", k),    64'(y0), 64'(e_y));
            step(1);
        end
        check("scan_wrap_inv", 64'(wrap1), 64'h0);
        step(4);
        check("scan_at2_idx", 64'(idx0), 64'h2);

        // En gating
        en = 1'b0;
        step(1);
        check("enoff_y",     64'(y0), 64'h0);
        check("enoff_valid", 64'(valid0), 64'h0);
        check("enoff_idx",   64'(idx0), 64'h2);
        en = 1'b1; mode = 2'b01;
        step(1);
        check("hold_idle_y",     64'(y0), 64'h0);
        check("hold_idle_valid", 64'(valid0), 64'h0);
        check("hold_idle_idx",   64'(idx0), 64'h2);
        step(1);
        check("hold_idle_valid2", 64'(valid0), 64'h0);

        // Asynchronous reset in the middle of a scan step
        mode = 2'b10;
        step(2);
        check("prerst_valid", 64'(valid0), 64'h1);
        check("prerst_idx",   64'(idx0), 64'h2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_y",     64'(y0), 64'h0);
        check("arst_y_inv", 64'(y1), 64'hF);
        check("arst_idx",   64'(idx0), 64'h0);
        check("arst_valid", 64'(valid0), 64'h0);
        check("arst_wrap",  64'(wrap0), 64'h0);
        check("arst_done",  64'(done0), 64'h0);

        // SCAN_ONCE, N=3, SCAN_DIV=1
        mode = 2'b00; a = 3'd5;
        step(1);
        check("rst_held_idx", 64'(idx2), 64'h0);
        rst = 1'b0;
        step(1);
        check("once_load_idx", 64'(idx2), 64'h5);
        check("once_load_y",   64'(y2), 64'h20);
        mode = 2'b11;
        step(1);
        check("once_entry_idx", 64'(idx2), 64'h5);
        step(1);
        check("once_idx6", 64'(idx2), 64'h6);
        step(1);
        check("once_idx7",   64'(idx2), 64'h7);
        check("once_done7",  64'(done2), 64'h0);
        step(1);
        check("once_done",   64'(done2), 64'h1);
        check("once_d_idx",  64'(idx2), 64'h7);
        check("once_d_y",    64'(y2), 64'h80);
        check("once_d_valid", 64'(valid2), 64'h1);
        check("once_nowrap", 64'(wrap2), 64'h0);
        step(1);
        check("once_done_held", 64'(done2), 64'h1);
        check("once_y_held",    64'(y2), 64'h80);
        mode = 2'b01;
        step(1);
        check("once_exit_done", 64'(done2), 64'h0);
        check("once_exit_y",    64'(y2), 64'h80);
        mode = 2'b11;
        step(1);
        check("rearm_entry_done", 64'(done2), 64'h0);
        step(1);
        check("rearm_done", 64'(done2), 64'h1);

        // Mode switch mid-step, SCAN_DIV=4
        rst = 1'b1;
        step(1);
        rst = 1'b0; mode = 2'b00; a = 3'd0;
        step(1);
        mode = 2'b10;
        step(3);
        check("sw_scan_idx", 64'(idx3), 64'h0);
        mode = 2'b01;
        step(1);
        check("sw_hold_idx", 64'(idx3), 64'h0);
        step(2);
        check("sw_hold_idx2",  64'(idx3), 64'h0);
        check("sw_hold_valid", 64'(valid3), 64'h1);
        mode = 2'b10;
        step(1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sw_rescan_idx_c%0d", i), 64'(idx3), 64'h0);
            step(1);
        end
        check("sw_advance_idx", 64'(idx3), 64'h1);
        check("sw_advance_y",   64'(y3), 64'h2);
        check("sw_wrap",        64'(wrap3), 64'h0);
        check("sw_done",        64'(done3), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_nx_seq.md
# decoder_nx_seq

Registered, parametrised N-to-2^N one-hot decoder, the clocked successor to the team's combinational 2-to-4 decoder. It adds a registered output, a hold mode, a free-running scan mode and a single-pass scan mode with a programmable step period. It drives one-hot select lines: row/digit strobes, chip selects and mux enables, where glitch-free registered outputs and automatic scanning are needed.

## Interface
- N, 2, select width; output width is 2**N (derived, not overridable); legal range 1..6.
- SCAN_DIV, 1, clock cycles per scan step; legal range 1..65535.
- ACTIVE_LOW, 0, 1 inverts Y: active line 0, inactive lines 1.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- En  input  1  enable; 0 forces all Y lines inactive.
- A  input  N  select index, used in DECODE mode.
- mode  input  2  00 DECODE, 01 HOLD, 10 SCAN, 11 SCAN_ONCE.
- Y  output  2**N  registered one-hot of idx, polarity per ACTIVE_LOW.
- idx  output  N  current registered index.
- valid  output  1  Y carries a meaningful active line.
- wrap  output  1  one-cycle pulse when SCAN wraps from 2**N-1 to 0.
- done  output  1  SCAN_ONCE pass finished (level).

## Operation
- Reset values:
  - idx=0, valid=0, wrap=0, done=0, step counter=0, state IDLE.
  - Y = all 0, or all 1 when ACTIVE_LOW=1.
- States: IDLE, DECODE, HOLD, SCAN, ONCE, DONE.
  - With En=1, the next state follows mode.
  - With En=0, the next state is IDLE from any state.
  - DONE is entered only from ONCE.
- IDLE: Y inactive; valid=0; done=0; idx retained.
- DECODE: every edge sets idx<=A and valid<=1.
- HOLD:
  - idx and valid are unchanged.
  - If entered from IDLE, valid stays 0 and Y stays inactive.
- SCAN:
  - valid=1.
  - The step counter counts 0..SCAN_DIV-1.
  - At terminal count, idx<=idx+1 modulo 2**N and the counter clears.
  - wrap=1 for exactly the cycle in which idx first shows 0 after 2**N-1.
- ONCE:
  - Steps from the current idx as in SCAN; wrap is never asserted.
  - If idx=2**N-1 at terminal count, go to DONE instead of advancing.
  - If idx=2**N-1 already on entry, go to DONE after one full SCAN_DIV period.
- DONE:
  - idx and Y held; valid=1; done=1.
  - Stays while mode=11 and En=1.
  - Any mode change leaves DONE and clears done.
  - Re-arming requires mode to leave 11 for at least one cycle.
- Y is always onehot(idx) when valid=1 and En=1, otherwise inactive; XOR with ACTIVE_LOW is applied last.
- Mode change: the step counter clears on any state transition; the new mode acts from the next edge.
- Arithmetic: idx increments modulo 2**N; the step counter width is clog2(SCAN_DIV), minimum 1. SCAN_DIV=1 advances every cycle.

## Timing
- Latency: A or mode to Y/idx is 1 clock; no combinational path from inputs to outputs.
- En falling: Y inactive and valid=0 on the next edge.
- En rising: the mode takes effect on the following edge.
- SCAN step period: exactly SCAN_DIV cycles per index, including the first step after entry (the counter starts from 0).
- wrap, done and valid are registered, aligned with the Y/idx they describe.
- rst mid-scan: all outputs return to reset values immediately (asynchronous), not waiting for a clock. The first post-reset activity occurs on the first clk edge after rst deasserts.

## Test plan
- Reset: N=2, ACTIVE_LOW=0, assert rst mid-SCAN, no clock → Y=0000, idx=0, valid=0, wrap=0, done=0 immediately.
- DECODE: N=2, En=1, mode=00, A=3,0,2 on successive edges → Y=1000,0001,0100 one cycle later, valid=1. Repeat with ACTIVE_LOW=1 → Y=0111,1110,1011.
- SCAN: N=2, SCAN_DIV=3, start idx=0 → idx 0,1,2,3,0, each held 3 cycles; wrap high for only the first cycle of idx=0 after 3.
- SCAN_ONCE: N=3, SCAN_DIV=1, load idx=5 via DECODE then mode=11 → idx 5,6,7, then done=1 with Y=10000000 held. mode=01 → done=0 next cycle.
- En gating: N=2, in SCAN at idx=2, drop En → Y=0000, valid=0 next edge, idx stays 2. Raise En with mode=01 → Y stays 0000, valid=0.
- Mode switch mid-step: N=2, SCAN_DIV=4, switch SCAN→HOLD after 2 cycles then back to SCAN → idx frozen during HOLD; after return, the next advance is 4 full cycles later.
